// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: RV32I integer register file with a per-register
// pending-writer scoreboard feeding the decode stage.
//
// Ports:
//   clk, rst                 clock; asynchronous active-low reset
//   rs1Addr/rs2Addr          decode source addresses
//   rs1Used/rs2Used          decode actually reads the source
//   rs1Data/rs2Data          combinational source read data
//   issueValid/issueWEnable  decode presents an instruction / it writes rd
//   issueRdAddr              its destination
//   wbWEnable/wbRdAddr/wbData writeback retire port
//   isDataHazard             combinational stall request to decode
//   pendingFull              combinational: destination counter saturated
//   errUnderflow             sticky: retire to a register with no pending writer
//
// Build option: define RF_BYPASS_EN to forward the same-cycle writeback onto
// the source read ports and clear single-writer hazards in the retire cycle.
module regfile_scoreboard #(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned PEND_W   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        rs1Addr,
  input  logic [4:0]        rs2Addr,
  input  logic              rs1Used,
  input  logic              rs2Used,
  output logic [DATA_W-1:0] rs1Data,
  output logic [DATA_W-1:0] rs2Data,
  input  logic              issueValid,
  input  logic              issueWEnable,
  input  logic [4:0]        issueRdAddr,
  input  logic              wbWEnable,
  input  logic [4:0]        wbRdAddr,
  input  logic [DATA_W-1:0] wbData,
  output logic              isDataHazard,
  output logic              pendingFull,
  output logic              errUnderflow
);

  localparam int unsigned AW = 5;
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  logic [DATA_W-1:0] rf_q   [NUM_REGS];
  logic [PEND_W-1:0] pend_q [NUM_REGS];
  logic [PEND_W-1:0] pend_d [NUM_REGS];
  logic              err_q, err_d;

  logic              wb_act;
  logic [PEND_W-1:0] rs1_cnt, rs2_cnt, rd_cnt;
  logic              rs1_busy, rs2_busy;
  logic              issue_inc;

  // Writes to x0 are architecturally void.
  assign wb_act  = wbWEnable && (wbRdAddr != '0);
  assign rs1_cnt = pend_q[rs1Addr];
  assign rs2_cnt = pend_q[rs2Addr];
  assign rd_cnt  = pend_q[issueRdAddr];

  // Source busy = effective pending count is nonzero.
`ifdef RF_BYPASS_EN
  // A retiring writer to this source already counts as gone.
  assign rs1_busy = (wb_act && (wbRdAddr == rs1Addr)) ? (rs1_cnt > PEND_W'(1)) : (rs1_cnt != '0);
  assign rs2_busy = (wb_act && (wbRdAddr == rs2Addr)) ? (rs2_cnt > PEND_W'(1)) : (rs2_cnt != '0);
  assign rs1Data  = (rs1Addr == '0) ? '0 :
                    (wb_act && (wbRdAddr == rs1Addr)) ? wbData : rf_q[rs1Addr];
  assign rs2Data  = (rs2Addr == '0) ? '0 :
                    (wb_act && (wbRdAddr == rs2Addr)) ? wbData : rf_q[rs2Addr];
`else
  assign rs1_busy = (rs1_cnt != '0);
  assign rs2_busy = (rs2_cnt != '0);
  assign rs1Data  = (rs1Addr == '0) ? '0 : rf_q[rs1Addr];
  assign rs2Data  = (rs2Addr == '0) ? '0 : rf_q[rs2Addr];
`endif

  // Stall while any used nonzero source still has an outstanding writer.
  assign isDataHazard = issueValid &&
                        ((rs1Used && (rs1Addr != '0) && rs1_busy) ||
                         (rs2Used && (rs2Addr != '0) && rs2_busy));

  // A same-cycle retire on the destination frees a slot, so no refusal then.
  assign pendingFull = issueValid && issueWEnable && (issueRdAddr != '0) &&
                       (rd_cnt == PEND_MAX) &&
                       !(wbWEnable && (wbRdAddr == issueRdAddr));

  assign issue_inc = issueValid && !isDataHazard && !pendingFull &&
                     issueWEnable && (issueRdAddr != '0);

  // Next-state counters and sticky underflow flag.
  always_comb begin
    err_d = err_q;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      pend_d[i] = pend_q[i];
      if (issue_inc && (issueRdAddr == AW'(i)) && !(wb_act && (wbRdAddr == AW'(i)))) begin
        pend_d[i] = pend_q[i] + PEND_W'(1);
      end else if (wb_act && (wbRdAddr == AW'(i)) &&
                   !(issue_inc && (issueRdAddr == AW'(i))) && (pend_q[i] != '0)) begin
        pend_d[i] = pend_q[i] - PEND_W'(1);
      end
    end
    if (wb_act && (pend_q[wbRdAddr] == '0)) begin
      err_d = 1'b1;
    end
  end

  // State registers: array, counters, error flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        rf_q[i]   <= '0;
        pend_q[i] <= '0;
      end
      err_q <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        pend_q[i] <= pend_d[i];
      end
      if (wb_act) begin
        rf_q[wbRdAddr] <= wbData;
      end
      err_q <= err_d;
    end
  end

  assign errUnderflow = err_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
module tb_regfile_scoreboard;

`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam int MAXP = 3;

  logic        clk, rst;
  logic [4:0]  rs1Addr, rs2Addr, issueRdAddr, wbRdAddr;
  logic        rs1Used, rs2Used, issueValid, issueWEnable, wbWEnable;
  logic [31:0] rs1Data, rs2Data, wbData;
  logic        isDataHazard, pendingFull, errUnderflow;

  regfile_scoreboard dut (
    .clk(clk), .rst(rst),
    .rs1Addr(rs1Addr), .rs2Addr(rs2Addr), .rs1Used(rs1Used), .rs2Used(rs2Used),
    .rs1Data(rs1Data), .rs2Data(rs2Data),
    .issueValid(issueValid), .issueWEnable(issueWEnable), .issueRdAddr(issueRdAddr),
    .wbWEnable(wbWEnable), .wbRdAddr(wbRdAddr), .wbData(wbData),
    .isDataHazard(isDataHazard), .pendingFull(pendingFull), .errUnderflow(errUnderflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: register values, outstanding-writer counts, error flag.
  logic [31:0] mreg [32];
  int          mpend[32];
  bit          merr;

  function automatic int eff(input logic [4:0] a);
    int e;
    e = mpend[a];
    if (BYP && wbWEnable && (wbRdAddr == a) && (a != 0) && (e > 0)) e--;
    return e;
  endfunction

  function automatic bit exp_haz();
    return issueValid && ((rs1Used && rs1Addr != 0 && eff(rs1Addr) != 0) ||
                          (rs2Used && rs2Addr != 0 && eff(rs2Addr) != 0));
  endfunction

  function automatic bit exp_full();
    return issueValid && issueWEnable && issueRdAddr != 0 &&
           mpend[issueRdAddr] == MAXP && !(wbWEnable && wbRdAddr == issueRdAddr);
  endfunction

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (BYP && wbWEnable && wbRdAddr == a) return wbData;
    return mreg[a];
  endfunction

  always @(posedge clk or negedge rst) begin : model
    bit acc, inc, dec;
    if (!rst) begin
      for (int i = 0; i < 32; i++) begin
        mreg[i]  = 32'h0;
        mpend[i] = 0;
      end
      merr = 1'b0;
    end else begin
      acc = issueValid && !exp_haz() && !exp_full();
      inc = acc && issueWEnable && issueRdAddr != 0;
      dec = wbWEnable && wbRdAddr != 0;
      if (dec && mpend[wbRdAddr] == 0) merr = 1'b1;
      if (dec) mreg[wbRdAddr] = wbData;
      if (!(inc && dec && issueRdAddr == wbRdAddr)) begin
        if (inc) mpend[issueRdAddr]++;
        if (dec && mpend[wbRdAddr] > 0) mpend[wbRdAddr]--;
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (rst) begin
      chk("rs1Data", rs1Data, exp_rd(rs1Addr));
      chk("rs2Data", rs2Data, exp_rd(rs2Addr));
      chk("isDataHazard", 32'(isDataHazard), 32'(exp_haz()));
      chk("pendingFull", 32'(pendingFull), 32'(exp_full()));
      chk("errUnderflow", 32'(errUnderflow), 32'(merr));
    end
  end

  task automatic idle();
    rs1Addr = 0; rs2Addr = 0; rs1Used = 0; rs2Used = 0;
    issueValid = 0; issueWEnable = 0; issueRdAddr = 0;
    wbWEnable = 0; wbRdAddr = 0; wbData = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] rd);
    idle(); issueValid = 1; issueWEnable = 1; issueRdAddr = rd;
  endtask

  task automatic retire(input logic [4:0] rd, input logic [31:0] d);
    idle(); wbWEnable = 1; wbRdAddr = rd; wbData = d;
  endtask

  initial begin
    idle();
    rst = 0;
    repeat (2) cyc();
    rst = 1;
    #1;
    rs1Addr = 5;
    #1 chk("reset rs1Data", rs1Data, 32'h0);
    chk("reset hazard", 32'(isDataHazard), 32'h0);
    chk("reset err", 32'(errUnderflow), 32'h0);
    cyc();

    // RAW hazard on x5, written back three cycles after issue.
    issue(5);
    #1 chk("A0 hazard", 32'(isDataHazard), 32'h0);
    cyc();
    idle(); issueValid = 1; rs1Used = 1; rs1Addr = 5;
    #1 chk("A1 hazard", 32'(isDataHazard), 32'h1);
    cyc();
    #1 chk("A2 hazard", 32'(isDataHazard), 32'h1);
    cyc();
    wbWEnable = 1; wbRdAddr = 5; wbData = 32'hDEAD;
    #1 chk("A3 hazard", 32'(isDataHazard), BYP ? 32'h0 : 32'h1);
    chk("A3 rs1Data", rs1Data, BYP ? 32'hDEAD : 32'h0);
    cyc();
    wbWEnable = 0;
    #1 chk("A4 hazard", 32'(isDataHazard), 32'h0);
    chk("A4 rs1Data", rs1Data, 32'hDEAD);
    cyc();

    // x0 writes are discarded; rd=0 never stalls or saturates.
    retire(0, 32'hFFFF); rs1Addr = 0; rs1Used = 1;
    #1 chk("x0 same-cycle", rs1Data, 32'h0);
    cyc();
    for (int k = 0; k < 5; k++) begin
      issue(0); rs1Used = 1; rs1Addr = 0;
      #1 chk("x0 issue hazard", 32'(isDataHazard), 32'h0);
      chk("x0 issue full", 32'(pendingFull), 32'h0);
      chk("x0 read", rs1Data, 32'h0);
      cyc();
    end

    // Saturate x7.
    for (int k = 0; k < 3; k++) begin
      issue(7);
      #1 chk("x7 fill full", 32'(pendingFull), 32'h0);
      cyc();
    end
    issue(7);
    #1 chk("x7 4th full", 32'(pendingFull), 32'h1);
    cyc();
    #1 chk("x7 still full", 32'(pendingFull), 32'h1);
    cyc();
    wbWEnable = 1; wbRdAddr = 7; wbData = 32'h77;
    #1 chk("x7 issue+retire full", 32'(pendingFull), 32'h0);
    cyc();
    wbWEnable = 0;
    #1 chk("x7 held at max", 32'(pendingFull), 32'h1);
    cyc();
    for (int k = 0; k < 3; k++) begin
      retire(7, 32'h700 + 32'(k));
      cyc();
    end
    idle(); issueValid = 1; rs1Used = 1; rs1Addr = 7;
    #1 chk("x7 drained hazard", 32'(isDataHazard), 32'h0);
    chk("x7 data", rs1Data, 32'h702);
    cyc();

    // Retire with no pending writer.
    retire(9, 32'h99);
    #1 chk("x9 err before edge", 32'(errUnderflow), 32'h0);
    cyc();
    idle(); issueValid = 1; rs1Used = 1; rs1Addr = 9;
    #1 chk("x9 err", 32'(errUnderflow), 32'h1);
    chk("x9 data", rs1Data, 32'h99);
    chk("x9 hazard", 32'(isDataHazard), 32'h0);
    repeat (3) cyc();
    #1 chk("x9 err held", 32'(errUnderflow), 32'h1);

    // Unused source does not stall.
    issue(4);
    cyc();
    issue(6); rs1Addr = 4; rs1Used = 0; rs2Addr = 3; rs2Used = 1;
    #1 chk("unused rs1 hazard", 32'(isDataHazard), 32'h0);
    cyc();
    idle(); issueValid = 1; rs1Used = 1; rs1Addr = 6;
    #1 chk("x6 accepted", 32'(isDataHazard), 32'h1);
    cyc();

    // Asynchronous reset during a stall on x5.
    retire(5, 32'h1234);
    cyc();
    issue(5);
    cyc();
    idle(); issueValid = 1; rs1Used = 1; rs1Addr = 5;
    #1 chk("pre-reset hazard", 32'(isDataHazard), 32'h1);
    chk("pre-reset data", rs1Data, 32'h1234);
    #1 rst = 0;
    #1 chk("async rs1Data", rs1Data, 32'h0);
    chk("async hazard", 32'(isDataHazard), 32'h0);
    chk("async err", 32'(errUnderflow), 32'h0);
    cyc();
    rst = 1;

    // Randomized traffic over x0..x7 to create frequent conflicts.
    for (int n = 0; n < 3000; n++) begin
      logic [4:0] w;
      idle();
      rs1Addr = 5'($urandom_range(0, 7));
      rs2Addr = 5'($urandom_range(0, 7));
      rs1Used = 1'($urandom);
      rs2Used = 1'($urandom);
      issueValid = ($urandom_range(0, 3) != 0);
      issueWEnable = 1'($urandom);
      issueRdAddr = 5'($urandom_range(0, 7));
      w = 5'($urandom_range(0, 7));
      if (n < 2000) begin
        for (int t = 0; t < 8 && mpend[w] == 0; t++) w = 5'($urandom_range(1, 7));
      end
      wbWEnable = ($urandom_range(0, 2) != 0);
      wbRdAddr = w;
      wbData = $urandom;
      if (n == 1500) begin
        rst = 0;
        #1 rst = 1;
      end
      cyc();
    end

    idle();
    cyc();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
